pixel_row_readout: RTL and testbench

Downstream consumer of the sensor state controller's read phase. On each new_row strobe it waits a settle delay, then captures the full row of pixel digital values from the array bus. It encodes the one-hot row select into a row index. Captured rows go into a two-row ping-pong buffer and are serialised pixel-by-pixel onto a valid/ready stream with position and framing flags for the frame store / output interface.

---
 rtl/pixel_row_readout_pkg.sv | 30 +++
 rtl/pixel_row_readout_row_pingpong_buf.sv | 50 +++++
 rtl/pixel_row_readout.sv | 166 ++++++++++++++++
 tb/tb_pixel_row_readout.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_row_readout_pkg.sv
// Shared configuration for the pixel row readout path: array geometry, index widths,
// row/entry types and the capture FSM state encoding.
package pixel_row_readout_pkg;

  localparam int PIXEL_ARRAY_WIDTH  = 4;
  localparam int PIXEL_ARRAY_HEIGHT = 4;
  localparam int PIXEL_BITS         = 8;

  // Index width that never collapses to zero bits for a 1-entry dimension.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_IDX_BITS = idx_bits(PIXEL_ARRAY_HEIGHT);
  localparam int COL_IDX_BITS = idx_bits(PIXEL_ARRAY_WIDTH);

  typedef logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_t;

  typedef struct packed {
    logic [ROW_IDX_BITS-1:0] row;
    row_t                    data;
  } row_entry_t;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_WAIT    = 2'd1,
    CAP_CAPTURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pixel_row_readout_row_pingpong_buf.sv
// Two-slot ping-pong row buffer. A write and a free in the same cycle while full
// reuse the slot being freed (wptr == rptr in that case), leaving count unchanged.
module row_pingpong_buf #(
  parameter int ENTRY_BITS = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ENTRY_BITS-1:0] i_wr_entry,
  input  logic                  i_free,
  output logic [ENTRY_BITS-1:0] o_rd_entry,
  output logic [1:0]            o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [ENTRY_BITS-1:0] r_slot [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_slot[r_wptr] <= i_wr_entry;
        r_wptr         <= ~r_wptr;
      end
      if (i_free) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_wr_en, i_free})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_entry = r_slot[r_rptr];
  assign o_count    = r_count;
  assign o_full     = (r_count == 2'd2);
  assign o_empty    = (r_count == 2'd0);

endmodule

// File: rtl/pixel_row_readout.sv
// Captures a sensor row a fixed delay after each new_row strobe, buffers up to two
// rows and serialises them pixel-by-pixel onto a valid/ready stream with framing flags.
module pixel_row_readout
  import pixel_row_readout_pkg::*;
#(
  parameter int WIDTH         = PIXEL_ARRAY_WIDTH,
  parameter int HEIGHT        = PIXEL_ARRAY_HEIGHT,
  parameter int BITS          = PIXEL_BITS,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_row,
  input  logic [HEIGHT-1:0]            row_select,
  input  logic [WIDTH*BITS-1:0]        pixel_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITS-1:0]              out_data,
  output logic [idx_bits(WIDTH)-1:0]   out_col,
  output logic [idx_bits(HEIGHT)-1:0]  out_row,
  output logic                         out_sof,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         overflow,
  output logic                         row_err,
  output cap_state_t                   dbg_state
);

  localparam int COL_W      = idx_bits(WIDTH);
  localparam int ROW_W      = idx_bits(HEIGHT);
  localparam int DLY_W      = idx_bits(CAPTURE_DELAY);
  localparam int DATA_BITS  = WIDTH * BITS;
  localparam int ENTRY_BITS = ROW_W + DATA_BITS;

  typedef logic [WIDTH-1:0][BITS-1:0] local_row_t;

  // Stream handshake: a beat moves when out_valid & out_ready at a rising edge.
  // out_valid depends only on buffer occupancy, so it cannot drop before the
  // current beat is taken, and the beat fields are pure functions of registers.

  cap_state_t             r_state;
  logic [DLY_W-1:0]       r_dly;
  logic                   r_overflow;
  logic                   r_row_err;
  logic [COL_W-1:0]       r_col;

  logic                   w_transfer;
  logic                   w_last_col;
  logic                   w_free;
  logic                   w_capture;
  logic                   w_onehot;
  logic [ROW_W-1:0]       w_row_idx;
  logic                   w_wr_en;
  logic [ENTRY_BITS-1:0]  w_wr_entry;
  logic [ENTRY_BITS-1:0]  w_rd_entry;
  logic [1:0]             w_count;
  logic                   w_full;
  logic                   w_empty;
  local_row_t             w_rd_pix;
  logic [ROW_W-1:0]       w_rd_row;

  assign w_transfer = out_valid & out_ready;
  assign w_last_col = (r_col == COL_W'(WIDTH - 1));
  assign w_free     = w_transfer & w_last_col;

  // A fresh new_row in the final WAIT cycle supersedes the pending capture.
  assign w_capture  = (r_state == CAP_WAIT) && (r_dly == '0) && !new_row;

  assign w_onehot = (row_select != '0) &&
                    ((row_select & (row_select - HEIGHT'(1))) == '0);

  // OR-reduction encoder: meaningful only when row_select is one-hot.
  always_comb begin
    w_row_idx = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (row_select[r]) begin
        w_row_idx = w_row_idx | ROW_W'(r);
      end
    end
  end

  assign w_wr_en    = w_capture && w_onehot && (!w_full || w_free);
  assign w_wr_entry = {w_row_idx, pixel_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= CAP_IDLE;
      r_dly      <= '0;
      r_overflow <= 1'b0;
      r_row_err  <= 1'b0;
    end else begin
      case (r_state)
        CAP_IDLE: begin
          if (new_row) begin
            r_state <= CAP_WAIT;
            r_dly   <= DLY_W'(CAPTURE_DELAY - 1);
          end
        end
        CAP_WAIT: begin
          if (new_row) begin
            r_dly <= DLY_W'(CAPTURE_DELAY - 1);
          end else if (r_dly == '0) begin
            r_state <= CAP_CAPTURE;
          end else begin
            r_dly <= r_dly - DLY_W'(1);
          end
        end
        CAP_CAPTURE: begin
          if (new_row) begin
            r_state <= CAP_WAIT;
            r_dly   <= DLY_W'(CAPTURE_DELAY - 1);
          end else begin
            r_state <= CAP_IDLE;
          end
        end
        default: begin
          r_state <= CAP_IDLE;
        end
      endcase

      if (w_capture && !w_onehot) begin
        r_row_err <= 1'b1;
      end
      if (w_capture && w_onehot && w_full && !w_free) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
    end else if (w_transfer) begin
      r_col <= w_last_col ? '0 : r_col + COL_W'(1);
    end
  end

  row_pingpong_buf #(
    .ENTRY_BITS (ENTRY_BITS)
  ) u_buf (
    .clk        (clk),
    .rst_n      (reset),
    .i_wr_en    (w_wr_en),
    .i_wr_entry (w_wr_entry),
    .i_free     (w_free),
    .o_rd_entry (w_rd_entry),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_rd_pix = w_rd_entry[DATA_BITS-1:0];
  assign w_rd_row = w_rd_entry[ENTRY_BITS-1:DATA_BITS];

  assign out_valid = !w_empty && (w_count != 2'd3);
  assign out_data  = w_rd_pix[r_col];
  assign out_col   = r_col;
  assign out_row   = w_rd_row;
  assign out_sof   = out_valid && (w_rd_row == '0) && (r_col == '0);
  assign out_eol   = out_valid && w_last_col;
  assign out_eof   = out_eol && (w_rd_row == ROW_W'(HEIGHT - 1));
  assign overflow  = r_overflow;
  assign row_err   = r_row_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pixel_row_readout.sv
// Directed plus randomized bench for pixel_row_readout, checked against a queue of
// expected stream beats built from row captures.
module tb_pixel_row_readout;
  import pixel_row_readout_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int B  = 8;
  localparam int CD = 2;

  logic             clk;
  logic             reset;
  logic             new_row;
  logic [H-1:0]     row_select;
  logic [W*B-1:0]   pixel_data;
  logic             out_valid;
  logic             out_ready;
  logic [B-1:0]     out_data;
  logic [1:0]       out_col;
  logic [1:0]       out_row;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
  logic             overflow;
  logic             row_err;
  cap_state_t       dbg_state;

  typedef struct packed {
    logic [B-1:0] data;
    logic [1:0]   col;
    logic [1:0]   row;
    logic         sof;
    logic         eol;
    logic         eof;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_ovf;
  logic  exp_err;
  int    pend;
  int    checks;
  int    errors;

  pixel_row_readout #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .BITS          (B),
    .CAPTURE_DELAY (CD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .new_row    (new_row),
    .row_select (row_select),
    .pixel_data (pixel_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_row    (out_row),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .overflow   (overflow),
    .row_err    (row_err),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_pixels();
    for (int c = 0; c < W; c++) pixel_data[c*B +: B] = B'($urandom);
  endtask

  // Row capture as the stream consumer sees it: a bad select is flagged, a third
  // resident row is dropped, otherwise the row's W beats join the end of the queue.
  task automatic model_capture();
    int n;
    int idx;
    int rows_held;
    beat_t b;
    n = 0;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      if (row_select[r]) begin
        n++;
        idx = r;
      end
    end
    rows_held = (exp_q.size() + W - 1) / W;
    if (n != 1) begin
      exp_err = 1'b1;
    end else if (rows_held >= 2) begin
      exp_ovf = 1'b1;
    end else begin
      for (int c = 0; c < W; c++) begin
        b.data = pixel_data[c*B +: B];
        b.col  = 2'(c);
        b.row  = 2'(idx);
        b.sof  = (idx == 0) && (c == 0);
        b.eol  = (c == W - 1);
        b.eof  = (c == W - 1) && (idx == H - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs, advance the model, step.
  task automatic cycle();
    beat_t b;
    chk("valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      b = exp_q[0];
      chk("data", out_data, b.data);
      chk("col",  out_col,  b.col);
      chk("row",  out_row,  b.row);
      chk("sof",  out_sof,  b.sof);
      chk("eol",  out_eol,  b.eol);
      chk("eof",  out_eof,  b.eof);
    end
    chk("overflow", overflow, exp_ovf);
    chk("row_err",  row_err,  exp_err);
    if (exp_q.size() != 0 && out_ready === 1'b1) void'(exp_q.pop_front());
    if (new_row) begin
      pend = CD;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) model_capture();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [H-1:0] sel);
    row_select = sel;
    rand_pixels();
    new_row = 1'b1;
    cycle();
    new_row = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ovf",   overflow,  1'b0);
    chk("rst_err",   row_err,   1'b0);
    chk("rst_state", dbg_state, CAP_IDLE);
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    pend    = 0;
    new_row = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_ovf    = 1'b0;
    exp_err    = 1'b0;
    pend       = 0;
    reset      = 1'b0;
    new_row    = 1'b0;
    row_select = '0;
    pixel_data = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data",  out_data,  8'h00);
    chk("reset_col",   out_col,   2'd0);
    chk("reset_row",   out_row,   2'd0);
    chk("reset_sof",   out_sof,   1'b0);
    chk("reset_eol",   out_eol,   1'b0);
    chk("reset_eof",   out_eof,   1'b0);
    chk("reset_ovf",   overflow,  1'b0);
    chk("reset_err",   row_err,   1'b0);
    chk("reset_state", dbg_state, CAP_IDLE);
    reset = 1'b1;

    // Single row, fixed pixels 0x10..0x13, latency from new_row.
    out_ready  = 1'b1;
    row_select = 4'b0001;
    pixel_data = {8'h13, 8'h12, 8'h11, 8'h10};
    new_row    = 1'b1;
    cycle();
    new_row = 1'b0;
    idle(2);
    chk("first_valid", out_valid, 1'b1);
    chk("first_data",  out_data,  8'h10);
    idle(6);

    // Full frame at 5-cycle row spacing.
    for (int r = 0; r < H; r++) begin
      pulse(4'(1 << r));
      idle(4);
    end
    idle(6);

    // No consumer: two rows buffered, third dropped.
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      pulse(4'(1 << r));
      idle(4);
    end
    idle(3);
    out_ready = 1'b1;
    idle(12);

    do_reset();

    // Toggling backpressure across two rows.
    for (int i = 0; i < 30; i++) begin
      out_ready = i[0];
      new_row   = 1'b0;
      if (i == 0 || i == 6) begin
        row_select = (i == 0) ? 4'b0100 : 4'b1000;
        rand_pixels();
        new_row = 1'b1;
      end
      cycle();
    end
    out_ready = 1'b1;
    idle(4);

    // Invalid select then a good row.
    pulse(4'b0110);
    idle(5);
    pulse(4'b0000);
    idle(5);
    pulse(4'b0100);
    idle(8);

    // Reset while a row is mid-stream.
    pulse(4'b0001);
    idle(4);
    do_reset();
    idle(2);

    // Re-pulse during WAIT: one capture, after the second pulse.
    pulse(4'b0010);
    pulse(4'b0010);
    idle(8);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      new_row   = ($urandom_range(0, 4) == 0);
      if (new_row) begin
        if ($urandom_range(0, 7) == 0) row_select = 4'($urandom);
        else row_select = 4'(1 << $urandom_range(0, H - 1));
        rand_pixels();
      end
      cycle();
    end
    new_row   = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
